// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MFHI  = 3'd4,
      OP_MFLO  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MBUSY = 2'd1,
      DBUSY = 2'd2
   } md_state_e;

   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: launches the iterative units, gates their completion
// into HI/LO, handles MTHI/MTLO, divide-by-zero, abort and a busy watchdog.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 7
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       md_valid,
   input  logic [2:0] md_op,
   input  logic       divisor_zero,
   input  logic       md_abort,
   input  logic       mult_done,
   input  logic       div_done,
   output logic       mult_start,
   output logic       div_start,
   output logic       md_signed,
   output logic       unit_cancel,
   output logic       mult_wr,
   output logic       div_wr,
   output logic       hi_lo_en,
   output logic       hi_lo_sel,
   output logic       md_stall,
   output logic       busy,
   output logic       dz_pulse,
   output logic       timeout_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             launch, signed_nxt, unit_done;
   md_op_e           op;

   assign op       = md_op_e'(md_op);
   assign busy     = (state != IDLE);
   assign md_stall = md_valid & busy & ~md_abort;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         cnt       <= '0;
         md_signed <= 1'b0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            cnt       <= '0;
            md_signed <= signed_nxt;
         end else if (busy) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Priority while busy: abort, then the matching done, then the watchdog.
   always_comb begin
      state_nxt   = state;
      launch      = 1'b0;
      signed_nxt  = 1'b0;
      mult_start  = 1'b0;
      div_start   = 1'b0;
      unit_cancel = 1'b0;
      mult_wr     = 1'b0;
      div_wr      = 1'b0;
      hi_lo_en    = 1'b0;
      hi_lo_sel   = 1'b0;
      dz_pulse    = 1'b0;
      timeout_err = 1'b0;
      unit_done   = (state == MBUSY) ? mult_done : div_done;

      case (state)
         IDLE: begin
            if (md_valid && !md_abort) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     mult_start = 1'b1;
                     launch     = 1'b1;
                     signed_nxt = (op == OP_MULT);
                     state_nxt  = MBUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (divisor_zero) begin
                        dz_pulse = 1'b1;
                     end else begin
                        div_start  = 1'b1;
                        launch     = 1'b1;
                        signed_nxt = (op == OP_DIV);
                        state_nxt  = DBUSY;
                     end
                  end
                  OP_MTHI: begin
                     hi_lo_en  = 1'b1;
                     hi_lo_sel = 1'b1;
                  end
                  OP_MTLO: hi_lo_en = 1'b1;
                  default: ;
               endcase
            end
         end
         MBUSY, DBUSY: begin
            if (md_abort) begin
               unit_cancel = 1'b1;
               state_nxt   = IDLE;
            end else if (unit_done) begin
               mult_wr   = (state == MBUSY);
               div_wr    = (state == DBUSY);
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout_err = 1'b1;
               unit_cancel = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: two instances (watchdog 64 and 8) share stimulus
// and are compared each cycle against an operation-level model plus literal checks.
module tb_muldiv_ctrl;

   localparam int TO0 = 64;
   localparam int TO1 = 8;
   localparam int B_MS = 0, B_DS = 1, B_SG = 2, B_UC = 3, B_MW = 4, B_DW = 5;
   localparam int B_EN = 6, B_SEL = 7, B_ST = 8, B_BSY = 9, B_DZ = 10, B_TO = 11;

   logic       CLK = 1'b0;
   logic       RST;
   logic       md_valid, divisor_zero, md_abort, mult_done, div_done;
   logic [2:0] md_op;
   logic [11:0] o0, o1;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   muldiv_ctrl #(.TIMEOUT(TO0), .CNT_W(7)) dut0 (
      .CLK(CLK), .RST(RST), .md_valid(md_valid), .md_op(md_op),
      .divisor_zero(divisor_zero), .md_abort(md_abort),
      .mult_done(mult_done), .div_done(div_done),
      .mult_start(o0[B_MS]), .div_start(o0[B_DS]), .md_signed(o0[B_SG]),
      .unit_cancel(o0[B_UC]), .mult_wr(o0[B_MW]), .div_wr(o0[B_DW]),
      .hi_lo_en(o0[B_EN]), .hi_lo_sel(o0[B_SEL]), .md_stall(o0[B_ST]),
      .busy(o0[B_BSY]), .dz_pulse(o0[B_DZ]), .timeout_err(o0[B_TO])
   );

   muldiv_ctrl #(.TIMEOUT(TO1), .CNT_W(4)) dut1 (
      .CLK(CLK), .RST(RST), .md_valid(md_valid), .md_op(md_op),
      .divisor_zero(divisor_zero), .md_abort(md_abort),
      .mult_done(mult_done), .div_done(div_done),
      .mult_start(o1[B_MS]), .div_start(o1[B_DS]), .md_signed(o1[B_SG]),
      .unit_cancel(o1[B_UC]), .mult_wr(o1[B_MW]), .div_wr(o1[B_DW]),
      .hi_lo_en(o1[B_EN]), .hi_lo_sel(o1[B_SEL]), .md_stall(o1[B_ST]),
      .busy(o1[B_BSY]), .dz_pulse(o1[B_DZ]), .timeout_err(o1[B_TO])
   );

   // Model: which unit owns the operation (0 none, 1 mul, 2 div) and its age.
   typedef struct {
      int kind;
      int age;
      bit sgn;
   } mst_t;

   mst_t ms0, ms1;

   function automatic void step(input mst_t s, input int to,
                                output logic [11:0] e, output mst_t n);
      e = '0;
      n = s;
      e[B_SG] = s.sgn;
      if (s.kind != 0) begin
         e[B_BSY] = 1'b1;
         e[B_ST]  = md_valid & ~md_abort;
         if (md_abort) begin
            e[B_UC] = 1'b1; n.kind = 0;
         end else if (s.kind == 1 && mult_done) begin
            e[B_MW] = 1'b1; n.kind = 0;
         end else if (s.kind == 2 && div_done) begin
            e[B_DW] = 1'b1; n.kind = 0;
         end else if (s.age == to - 1) begin
            e[B_TO] = 1'b1; e[B_UC] = 1'b1; n.kind = 0;
         end else begin
            n.age = s.age + 1;
         end
      end else if (md_valid && !md_abort) begin
         case (md_op)
            3'd0, 3'd1: begin
               e[B_MS] = 1'b1; n.kind = 1; n.age = 0; n.sgn = (md_op == 3'd0);
            end
            3'd2, 3'd3: begin
               if (divisor_zero) e[B_DZ] = 1'b1;
               else begin
                  e[B_DS] = 1'b1; n.kind = 2; n.age = 0; n.sgn = (md_op == 3'd2);
               end
            end
            3'd6: begin e[B_EN] = 1'b1; e[B_SEL] = 1'b1; end
            3'd7: e[B_EN] = 1'b1;
            default: ;
         endcase
      end
   endfunction

   always @(posedge CLK or negedge RST) begin
      mst_t n;
      logic [11:0] e;
      if (!RST) begin
         ms0 = '{0, 0, 1'b0};
         ms1 = '{0, 0, 1'b0};
      end else begin
         step(ms0, TO0, e, n); ms0 = n;
         step(ms1, TO1, e, n); ms1 = n;
      end
   end

   always @(negedge CLK) begin
      mst_t n;
      logic [11:0] e;
      step(ms0, TO0, e, n);
      checks++;
      if (o0 !== e) begin
         failures++;
         $display("FAIL model0 t=%0t: got %b want %b", $time, o0, e);
      end
      step(ms1, TO1, e, n);
      checks++;
      if (o1 !== e) begin
         failures++;
         $display("FAIL model1 t=%0t: got %b want %b", $time, o1, e);
      end
   end

   task automatic lit(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic clr;
      md_valid = 0; md_op = 3'd0; divisor_zero = 0;
      md_abort = 0; mult_done = 0; div_done = 0;
   endtask

   initial begin
      RST = 1'b0;
      clr();
      ms0 = '{0, 0, 1'b0};
      ms1 = '{0, 0, 1'b0};
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      lit("reset_out0", o0, 12'h000);
      lit("reset_out1", o1, 12'h000);
      tick(); RST = 1'b1;

      // MULT, done on the 32nd busy cycle with a waiting MFLO
      tick(); md_valid = 1; md_op = 3'd0;
      @(negedge CLK); lit("mult_start", {11'b0, o0[B_MS]}, 12'd1);
      tick(); md_valid = 0;
      @(negedge CLK);
      lit("mult_signed", {11'b0, o0[B_SG]}, 12'd1);
      lit("mult_busy", {11'b0, o0[B_BSY]}, 12'd1);
      lit("mult_start_1cyc", {11'b0, o0[B_MS]}, 12'd0);
      repeat (31) tick();
      md_valid = 1; md_op = 3'd5; mult_done = 1;
      @(negedge CLK);
      lit("mult_wr", {11'b0, o0[B_MW]}, 12'd1);
      lit("mflo_stall_done", {11'b0, o0[B_ST]}, 12'd1);
      tick(); mult_done = 0;
      @(negedge CLK); lit("mflo_release", {10'b0, o0[B_ST], o0[B_BSY]}, 12'd0);
      tick(); clr();

      // DIVU by zero, then MTLO
      tick(); md_valid = 1; md_op = 3'd3; divisor_zero = 1;
      @(negedge CLK);
      lit("dz_pulse", {11'b0, o0[B_DZ]}, 12'd1);
      lit("dz_nostart", {9'b0, o0[B_DS], o0[B_BSY], o0[B_ST]}, 12'd0);
      tick(); md_op = 3'd7; divisor_zero = 0;
      @(negedge CLK); lit("mtlo", {10'b0, o0[B_EN], o0[B_SEL]}, 12'b10);
      tick(); clr();

      // MULTU, MTHI stalled from busy cycle 3 until done on cycle 6
      tick(); md_valid = 1; md_op = 3'd1;
      @(negedge CLK); lit("multu_start", {11'b0, o0[B_MS]}, 12'd1);
      tick(); md_valid = 0;
      @(negedge CLK); lit("multu_unsigned", {11'b0, o0[B_SG]}, 12'd0);
      tick();
      tick(); md_valid = 1; md_op = 3'd6;
      @(negedge CLK); lit("mthi_stall", {10'b0, o0[B_ST], o0[B_EN]}, 12'b10);
      tick(); tick();
      tick(); mult_done = 1;
      @(negedge CLK); lit("multu_wr_stall", {9'b0, o0[B_MW], o0[B_ST], o0[B_EN]}, 12'b110);
      tick(); mult_done = 0;
      @(negedge CLK); lit("mthi_accept", {9'b0, o0[B_EN], o0[B_SEL], o0[B_ST]}, 12'b110);
      tick(); clr();

      // DIV aborted in the same cycle as div_done
      tick(); md_valid = 1; md_op = 3'd2;
      @(negedge CLK); lit("div_start", {11'b0, o0[B_DS]}, 12'd1);
      tick(); md_valid = 0;
      tick(); tick(); md_abort = 1; div_done = 1;
      @(negedge CLK); lit("abort_cancel", {10'b0, o0[B_UC], o0[B_DW]}, 12'b10);
      tick(); clr();
      @(negedge CLK); lit("abort_idle", {11'b0, o0[B_BSY]}, 12'd0);

      // Watchdog on the short instance, then immediate relaunch
      tick(); md_valid = 1; md_op = 3'd2;
      tick(); md_valid = 0;
      repeat (6) tick();
      @(negedge CLK); lit("to_not_yet", {11'b0, o1[B_TO]}, 12'd0);
      tick();
      @(negedge CLK); lit("timeout", {10'b0, o1[B_TO], o1[B_UC]}, 12'b11);
      tick(); md_valid = 1; md_op = 3'd2;
      @(negedge CLK);
      lit("relaunch", {11'b0, o1[B_DS]}, 12'd1);
      lit("relaunch_stall0", {11'b0, o0[B_ST]}, 12'd1);
      tick(); clr(); md_abort = 1;
      tick(); clr();

      // Done coinciding with the watchdog cycle wins
      tick(); md_valid = 1; md_op = 3'd3;
      tick(); md_valid = 0;
      repeat (7) tick();
      div_done = 1;
      @(negedge CLK); lit("done_beats_to", {10'b0, o1[B_DW], o1[B_TO]}, 12'b10);
      tick(); clr();

      // Asynchronous reset in DBUSY at cnt=5
      tick(); md_valid = 1; md_op = 3'd2;
      tick(); md_valid = 0;
      repeat (5) tick();
      #2 RST = 1'b0;
      #1 lit("rst_async0", o0, 12'h000);
      lit("rst_async1", o1, 12'h000);
      tick(); RST = 1'b1;
      tick(); div_done = 1;
      @(negedge CLK); lit("post_rst_done", {11'b0, o0[B_DW]}, 12'd0);
      tick(); clr();
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
